// File: rtl/transpose_pkg.sv
// Shared definitions for the matrix-transpose path: byte size, geometry helpers
// and the walk state encoding used by the chunk sequencer and the store-address stage.
package transpose_pkg;

    localparam int BYTE = 8;

    function automatic int row_inc(input int data_width, input int arr_size);
        return data_width * arr_size / BYTE;
    endfunction

    function automatic int chunk_bytes(input int data_width, input int chunk_size);
        return data_width * chunk_size / BYTE;
    endfunction

    function automatic int nch(input int arr_size, input int chunk_size);
        return arr_size / chunk_size;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with synchronous clear, enable and a wrap strobe that
// fires on the enabled cycle in which the count rolls over from N-1 to 0.
module wrap_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max,
    output logic wrap
);

    localparam int           W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == MAX) ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign at_max = (count_q == MAX);
    assign wrap   = en && at_max;

endmodule

// File: rtl/chunk_addr_gen.sv
// Chunk address sequencer: walks an ARR_SIZE^2 matrix in CHUNK_SIZE^2 chunks, one beat per chunk row.
// Optional stall counter output enabled by defining CHUNK_ADDR_GEN_STALL_CNT_EN.
module chunk_addr_gen
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ARR_SIZE   = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNK_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  xpose_in,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] row_addr,
    output logic [ADDR_WIDTH-1:0] chunk_addr,
    output logic                  ctrl,
    output logic                  out_last,
    output logic                  busy,
`ifdef CHUNK_ADDR_GEN_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  done
);

    localparam int ROW_INC     = row_inc(DATA_WIDTH, ARR_SIZE);
    localparam int CHUNK_BYTES = chunk_bytes(DATA_WIDTH, CHUNK_SIZE);
    localparam int NCH         = nch(ARR_SIZE, CHUNK_SIZE);

    // Moving to the next chunk row jumps back over the NCH-1 chunks already crossed.
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(ROW_INC);
    localparam logic [ADDR_WIDTH-1:0] CJ_STEP  = ADDR_WIDTH'(CHUNK_BYTES);
    localparam logic [ADDR_WIDTH-1:0] CI_STEP  = ADDR_WIDTH'(CHUNK_SIZE * ROW_INC)
                                               - ADDR_WIDTH'((NCH - 1) * CHUNK_BYTES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic [ADDR_WIDTH-1:0] chunk_addr_q, chunk_addr_d;
    logic                  ctrl_q, ctrl_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic start_acc, xfer;
    logic r_max, r_wrap, cj_max, cj_wrap, ci_max, ci_wrap;

    assign start_acc = (state_q == IDLE) && start;
    assign xfer      = (state_q == RUN) && out_ready;

    // Counters step on every transfer; the ci wrap strobe marks the final beat.
    wrap_counter #(.N(CHUNK_SIZE)) u_r (
        .clk(clk), .rst(rst), .clr(start_acc), .en(xfer),
        .at_max(r_max), .wrap(r_wrap)
    );
    wrap_counter #(.N(NCH)) u_cj (
        .clk(clk), .rst(rst), .clr(start_acc), .en(r_wrap),
        .at_max(cj_max), .wrap(cj_wrap)
    );
    wrap_counter #(.N(NCH)) u_ci (
        .clk(clk), .rst(rst), .clr(start_acc), .en(cj_wrap),
        .at_max(ci_max), .wrap(ci_wrap)
    );

    always_comb begin
        state_d      = state_q;
        row_addr_d   = row_addr_q;
        chunk_addr_d = chunk_addr_q;
        ctrl_d       = ctrl_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    row_addr_d   = base_addr;
                    chunk_addr_d = base_addr;
                    ctrl_d       = xpose_in;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (ci_wrap) begin
                        state_d = DONE;
                    end else if (cj_wrap) begin
                        chunk_addr_d = chunk_addr_q + CI_STEP;
                        row_addr_d   = chunk_addr_q + CI_STEP;
                    end else if (r_wrap) begin
                        chunk_addr_d = chunk_addr_q + CJ_STEP;
                        row_addr_d   = chunk_addr_q + CJ_STEP;
                    end else begin
                        row_addr_d = row_addr_q + ROW_STEP;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == RUN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_addr_q   <= '0;
            chunk_addr_q <= '0;
            ctrl_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_addr_q   <= row_addr_d;
            chunk_addr_q <= chunk_addr_d;
            ctrl_q       <= ctrl_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef CHUNK_ADDR_GEN_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if ((state_q == RUN) && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign out_valid  = out_valid_q;
    assign row_addr   = row_addr_q;
    assign chunk_addr = chunk_addr_q;
    assign ctrl       = ctrl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    // Counters are registered and only non-zero while a walk is valid on the bus.
    assign out_last   = out_valid_q && r_max && cj_max && ci_max;

endmodule

// File: tb/tb_chunk_addr_gen.sv
// Scoreboard bench for chunk_addr_gen at default parameters (16 beats per walk).
module tb_chunk_addr_gen;

    typedef struct packed {
        logic [63:0] row;
        logic [63:0] chunk;
        logic        ctrl;
        logic        last;
    } beat_t;

    localparam logic [63:0] ROW_OFF [16] = '{
        64'h000, 64'h040, 64'h080, 64'h0C0, 64'h020, 64'h060, 64'h0A0, 64'h0E0,
        64'h100, 64'h140, 64'h180, 64'h1C0, 64'h120, 64'h160, 64'h1A0, 64'h1E0};
    localparam logic [63:0] CHUNK_OFF [16] = '{
        64'h000, 64'h000, 64'h000, 64'h000, 64'h020, 64'h020, 64'h020, 64'h020,
        64'h100, 64'h100, 64'h100, 64'h100, 64'h120, 64'h120, 64'h120, 64'h120};

    logic        clk;
    logic        rst;
    logic        start;
    logic        xpose_in;
    logic [63:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] row_addr;
    logic [63:0] chunk_addr;
    logic        ctrl;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef CHUNK_ADDR_GEN_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    chunk_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .xpose_in(xpose_in), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready), .row_addr(row_addr),
        .chunk_addr(chunk_addr), .ctrl(ctrl), .out_last(out_last), .busy(busy),
`ifdef CHUNK_ADDR_GEN_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q [$];
    int    beats_seen   = 0;
    int    valid_cycles = 0;
    int    done_cnt     = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares the head of the scoreboard on every valid cycle, pops on transfer.
    initial begin : monitor
        logic  done_exp;
        logic  done_prev;
        logic  done_exp_next;
        beat_t e;
        done_exp  = 1'b0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_exp  = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (done || done_exp) check("done_pulse", done, done_exp);
                if (done_prev) check("busy_fall", {busy, out_valid}, 2'b00);
                done_exp_next = 1'b0;
                if (out_valid) begin
                    valid_cycles++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", out_valid, 1'b0);
                    end else begin
                        e = exp_q[0];
                        check($sformatf("beat%0d", beats_seen),
                              {row_addr, chunk_addr, ctrl, out_last, busy},
                              {e.row, e.chunk, e.ctrl, e.last, 1'b1});
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            beats_seen++;
                            if (e.last) done_exp_next = 1'b1;
                        end
                    end
                end
                done_exp  = done_exp_next;
                done_prev = done;
                if (done) done_cnt++;
            end
        end
    end

    task automatic push_walk(input logic [63:0] b, input logic x);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{row: b + ROW_OFF[i], chunk: b + CHUNK_OFF[i], ctrl: x, last: (i == 15)});
        end
    endtask

    task automatic walk(input logic [63:0] b, input logic x, input bit toggle, input bit inject);
        int  d0;
        bit  finished;
        push_walk(b, x);
        d0           = done_cnt;
        valid_cycles = 0;
        beats_seen   = 0;
        finished     = 1'b0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        xpose_in  = x;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !finished; i++) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            out_ready = toggle ? ~out_ready : 1'b1;
            if (inject && i == 4) begin
                start     = 1'b1;
                base_addr = 64'h9000;
                xpose_in  = ~x;
            end
            if (done_cnt != d0) finished = 1'b1;
        end
        start = 1'b0;
        check("walk_done", done_cnt - d0, 1);
        check("walk_cycles", valid_cycles, toggle ? 32 : 16);
        check("queue_drained", exp_q.size(), 0);
`ifdef CHUNK_ADDR_GEN_STALL_CNT_EN
        if (toggle) check("stall_cnt", stall_cnt, 16);
`endif
        @(posedge clk);
        @(posedge clk);
    endtask

    initial begin : stimulus
        bit reached;
        rst       = 1'b1;
        start     = 1'b0;
        xpose_in  = 1'b0;
        base_addr = '0;
        out_ready = 1'b0;
        #3;
        check("reset_state", {out_valid, row_addr, chunk_addr, ctrl, out_last, busy, done}, '0);
        #9;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle", {out_valid, row_addr, chunk_addr, ctrl, out_last, busy, done}, '0);
        end

        walk(64'h1000, 1'b0, 1'b0, 1'b0);
        walk(64'h1000, 1'b0, 1'b1, 1'b0);
        walk(64'h4000, 1'b1, 1'b0, 1'b1);
        walk(64'h4000, 1'b0, 1'b0, 1'b0);
        walk(64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b1, 1'b0);

        // Abort a walk with reset while beat 5 is on the bus.
        push_walk(64'h1000, 1'b0);
        beats_seen = 0;
        reached    = 1'b0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 64'h1000;
        xpose_in  = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        push_walk(64'h1000, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(posedge clk);
            if (beats_seen >= 5) reached = 1'b1;
        end
        check("abort_reach_beat5", reached, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_zero", {out_valid, row_addr, chunk_addr, ctrl, out_last, busy, done}, '0);
        exp_q.delete();
        #9;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {done, busy, out_valid}, 3'b000);
        end

        walk(64'h0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
